// File: rtl/control_unit.sv
// Control unit for an 8-bit accumulator machine. A single multi-cycle FSM
// sequences opcode fetch, operand fetch, execute and store over a memory whose read data arrives one cycle late.
module control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] mem_rdata,
   input  logic       zero_flag,
   output logic [7:0] mem_address,
   output logic       mem_write_enable,
   output logic       acc_load,
   output logic       acc_src,
   output logic [3:0] alu_op,
   output logic [7:0] pc_out,
   output logic       halted
);

   typedef enum logic [2:0] {
      FETCH, DECODE, ARG, ARG_LATCH, READ, EXEC, STORE, HALT
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_JNZ = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] opr_q, opr_d;
   // Only the opcode nibble of the instruction register is ever decoded.
   logic [7:4] ir_q, ir_d;
   logic [3:0] newOpcode;
   logic       twoByte;

   assign newOpcode = mem_rdata[7:4];
   assign twoByte   = (newOpcode >= OP_LDA) && (newOpcode <= OP_JNZ);
   assign pc_out    = pc_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= 8'h00;
         ir_q    <= 4'h0;
         opr_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         opr_q   <= opr_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      ir_d             = ir_q;
      opr_d            = opr_q;
      mem_address      = pc_q;
      mem_write_enable = 1'b0;
      acc_load         = 1'b0;
      acc_src          = 1'b0;
      alu_op           = 4'h0;
      halted           = 1'b0;

      case (state_q)
         FETCH: begin
            if (run) state_d = DECODE;
         end
         DECODE: begin
            ir_d = newOpcode;
            pc_d = pc_q + 8'd1;
            if (twoByte)                  state_d = ARG;
            else if (newOpcode == OP_HLT) state_d = HALT;
            else                          state_d = FETCH;
         end
         ARG: begin
            state_d = ARG_LATCH;
         end
         ARG_LATCH: begin
            opr_d   = mem_rdata;
            pc_d    = pc_q + 8'd1;
            state_d = FETCH;
            // Taken branches replace the increment with the operand byte.
            case (ir_q)
               OP_JMP: pc_d = mem_rdata;
               OP_JZ:  if (zero_flag)  pc_d = mem_rdata;
               OP_JNZ: if (!zero_flag) pc_d = mem_rdata;
               OP_STA: state_d = STORE;
               OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = READ;
               default: state_d = FETCH;
            endcase
         end
         READ: begin
            mem_address = opr_q;
            state_d     = EXEC;
         end
         EXEC: begin
            mem_address = opr_q;
            acc_load    = 1'b1;
            if (ir_q != OP_LDA) begin
               acc_src = 1'b1;
               alu_op  = ir_q - OP_ADD;
            end
            state_d = FETCH;
         end
         STORE: begin
            mem_address      = opr_q;
            mem_write_enable = 1'b1;
            state_d          = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// [TB] Scoreboard bench for control_unit: a memory/accumulator model surrounds
// the DUT, stimulus queues expected strobes, and a monitor checks each strobe as it appears.
module tb_control_unit;

   logic       clk;
   logic       reset;
   logic       run;
   logic [7:0] mem_rdata;
   logic       zero_flag;
   logic [7:0] mem_address;
   logic       mem_write_enable;
   logic       acc_load;
   logic       acc_src;
   logic [3:0] alu_op;
   logic [7:0] pc_out;
   logic       halted;

   logic [7:0] mem [256];
   logic [7:0] acc;
   logic       zfOverrideEn;
   logic       zfOverrideVal;
   int         cyc;
   int         base;
   int         checks;
   int         passes;

   typedef struct {
      logic       isAcc;
      logic       isWr;
      logic       src;
      logic [3:0] op;
      logic [7:0] addr;
      logic [7:0] offset;
   } strobe_t;

   strobe_t expQ[$];

   control_unit dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .mem_rdata(mem_rdata),
      .zero_flag(zero_flag),
      .mem_address(mem_address),
      .mem_write_enable(mem_write_enable),
      .acc_load(acc_load),
      .acc_src(acc_src),
      .alu_op(alu_op),
      .pc_out(pc_out),
      .halted(halted)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to time strobes relative to the start of a run.
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memory: data appears the cycle after the address.
   always @(posedge clk) mem_rdata <= mem[mem_address];

   function automatic logic [7:0] aluModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   // Accumulator model driven by the DUT's load strobe and source/op selects.
   always @(posedge clk or negedge reset) begin
      if (!reset)        acc <= 8'h00;
      else if (acc_load) acc <= acc_src ? aluModel(alu_op, acc, mem_rdata) : mem_rdata;
   end

   assign zero_flag = zfOverrideEn ? zfOverrideVal : (acc == 8'h00);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic pushAcc(input logic src, input logic [3:0] op, input logic [7:0] offset);
      strobe_t e;
      e.isAcc = 1'b1; e.isWr = 1'b0; e.src = src; e.op = op; e.addr = 8'h00; e.offset = offset;
      expQ.push_back(e);
   endtask

   task automatic pushWrite(input logic [7:0] addr, input logic [7:0] offset);
      strobe_t e;
      e.isAcc = 1'b0; e.isWr = 1'b1; e.src = 1'b0; e.op = 4'h0; e.addr = addr; e.offset = offset;
      expQ.push_back(e);
   endtask

   // Monitor: every strobe cycle pops one expected entry; a strobe with nothing queued is an error.
   initial begin
      strobe_t     e;
      logic [31:0] got;
      logic [31:0] want;
      forever begin
         @(negedge clk);
         if (acc_load === 1'b1 || mem_write_enable === 1'b1) begin
            got = {9'd0, acc_load, mem_write_enable, acc_src, alu_op,
                   (mem_write_enable ? mem_address : 8'h00), 8'(cyc - base)};
            if (expQ.size() == 0) begin
               checkOutput("unexpected strobe", got, 32'h0);
            end else begin
               e    = expQ.pop_front();
               want = {9'd0, e.isAcc, e.isWr, e.src, e.op, e.addr, e.offset};
               checkOutput("strobe", got, want);
            end
         end
      end
   end

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic resetDut();
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
      expQ.delete();
      @(negedge clk);
      reset         = 1'b0;
      run           = 1'b0;
      zfOverrideEn  = 1'b0;
      zfOverrideVal = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset outputs",
                  {8'd0, pc_out, mem_address, mem_write_enable, acc_load, acc_src, alu_op, halted}, 32'h0);
      reset = 1'b1;
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      base = cyc;
      run  = 1'b1;
   endtask

   task automatic waitHalted(input string name, input logic [7:0] pcExp);
      for (int i = 0; i < 60 && halted !== 1'b1; i++) @(negedge clk);
      checkOutput({name, " halted"}, 32'(halted), 32'd1);
      checkOutput({name, " pc"}, 32'(pc_out), 32'(pcExp));
      checkOutput({name, " halt address"}, 32'(mem_address), 32'(pcExp));
   endtask

   // Directed scenarios, each started from a fresh reset.
   initial begin
      reset = 1'b0; run = 1'b0; zfOverrideEn = 1'b0; zfOverrideVal = 1'b0;
      checks = 0; passes = 0; base = 0;
      clearMem();

      // Idle with run low, then LDA/ADD/HLT.
      mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h21; mem[4] = 8'hF0;
      mem[8'h20] = 8'h05; mem[8'h21] = 8'h07;
      resetDut();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("idle outputs",
                     {8'd0, pc_out, mem_address, mem_write_enable, acc_load, acc_src, alu_op, halted}, 32'h0);
      end
      pushAcc(1'b0, 4'd0, 8'd5);
      pushAcc(1'b1, 4'd0, 8'd11);
      applyStimulus();
      waitHalted("lda-add", 8'h05);
      checkOutput("lda-add acc", 32'(acc), 32'h0C);

      // STA 0x40 then HLT.
      clearMem();
      mem[0] = 8'h20; mem[1] = 8'h40; mem[2] = 8'hF0;
      resetDut();
      pushWrite(8'h40, 8'd4);
      applyStimulus();
      waitHalted("sta", 8'h03);

      // JMP 0x10; JZ 0x80 at 0x10, taken then not taken.
      for (int t = 1; t >= 0; t--) begin
         clearMem();
         mem[0] = 8'h80; mem[1] = 8'h10; mem[8'h10] = 8'h90; mem[8'h11] = 8'h80;
         mem[8'h12] = 8'hF0; mem[8'h80] = 8'hF0;
         resetDut();
         zfOverrideEn  = 1'b1;
         zfOverrideVal = (t == 1);
         applyStimulus();
         repeat (8) @(negedge clk);
         checkOutput(t == 1 ? "jz taken pc" : "jz not-taken pc", 32'(pc_out), t == 1 ? 32'h80 : 32'h12);
         waitHalted(t == 1 ? "jz taken" : "jz not-taken", t == 1 ? 8'h81 : 8'h13);
      end

      // AND, JMP 0xFF, ADD whose operand byte wraps to address 0x00.
      clearMem();
      mem[0] = 8'h50; mem[1] = 8'hF2; mem[2] = 8'h80; mem[3] = 8'hFF;
      mem[8'hFF] = 8'h30; mem[8'h50] = 8'h11;
      resetDut();
      pushAcc(1'b1, 4'd2, 8'd5);
      pushAcc(1'b1, 4'd0, 8'd15);
      applyStimulus();
      repeat (10) @(negedge clk);
      checkOutput("wrap fetch pc", 32'(pc_out), 32'hFF);
      checkOutput("wrap fetch address", 32'(mem_address), 32'hFF);
      repeat (2) @(negedge clk);
      checkOutput("wrap arg pc", 32'(pc_out), 32'h00);
      checkOutput("wrap arg address", 32'(mem_address), 32'h00);
      repeat (2) @(negedge clk);
      checkOutput("wrap read address", 32'(mem_address), 32'h50);
      waitHalted("wrap", 8'h02);
      checkOutput("wrap acc", 32'(acc), 32'h11);

      // Asynchronous reset in the middle of an LDA's EXEC cycle, then restart.
      clearMem();
      mem[0] = 8'h10; mem[1] = 8'h20; mem[8'h20] = 8'h33;
      resetDut();
      pushAcc(1'b0, 4'd0, 8'd5);
      applyStimulus();
      repeat (5) @(negedge clk);
      checkOutput("exec acc_load", 32'(acc_load), 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async reset acc_load", 32'(acc_load), 32'd0);
      checkOutput("async reset pc", 32'(pc_out), 32'h00);
      checkOutput("async reset halted", 32'(halted), 32'd0);
      checkOutput("async reset address", 32'(mem_address), 32'h00);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run   = 1'b0;
      pushAcc(1'b0, 4'd0, 8'd5);
      applyStimulus();
      repeat (6) @(negedge clk);
      checkOutput("restart acc", 32'(acc), 32'h33);

      resetDut();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
